// File: rtl/sum_diff_pe_pkg.sv
// Shared types and helpers for the sum/difference PE array.
//
// Contents:
//   pe_op_e    - operation selected by a stage's sel bit (sum or difference)
//   out_width  - output lane width after STAGES levels of bit growth
//   sat_bound  - upper/lower limit of the signed DATA_WIDTH range, used by the
//                optional saturation build (SUM_DIFF_PE_SAT_EN)
package sum_diff_pe_pkg;

  typedef enum logic {
    PE_SUM  = 1'b0,
    PE_DIFF = 1'b1
  } pe_op_e;

  // Each stage adds one bit of growth, so a chain of stages widens by STAGES.
  function automatic int out_width(input int dw, input int stages);
    return dw + stages;
  endfunction

  // Limits of a signed dw-bit value; upper=1 gives the max, upper=0 the min.
  function automatic int sat_bound(input int dw, input bit upper);
    if (upper) begin
      return (1 << (dw - 1)) - 1;
    end
    return -(1 << (dw - 1));
  endfunction

endpackage

// File: rtl/sum_diff_pe_array_if.sv
// Handshake/data bundle of the sum/difference PE array.
//
// Signals:
//   in_valid / in_ready   input sample handshake
//   in_x                  CHANNELS signed samples, lane c at [c*DATA_WIDTH +: DATA_WIDTH]
//   in_load / in_sel      per-stage control vectors travelling with the sample
//   out_valid / out_ready output handshake
//   out_z                 CHANNELS signed results, lane c at [c*OUT_WIDTH +: OUT_WIDTH]
//   sat_flag              only when SUM_DIFF_PE_SAT_EN is defined
// Modports: master drives samples and accepts results; slave is the array.
interface sum_diff_pe_array_if #(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int STAGES     = 2
);

  localparam int OUT_WIDTH = sum_diff_pe_pkg::out_width(DATA_WIDTH, STAGES);

  logic                            in_valid;
  logic                            in_ready;
  logic [CHANNELS*DATA_WIDTH-1:0]  in_x;
  logic [STAGES-1:0]               in_load;
  logic [STAGES-1:0]               in_sel;
  logic                            out_valid;
  logic                            out_ready;
  logic [CHANNELS*OUT_WIDTH-1:0]   out_z;
`ifdef SUM_DIFF_PE_SAT_EN
  logic                            sat_flag;
`endif

  modport master (
    output in_valid, in_x, in_load, in_sel, out_ready,
    input  in_ready, out_valid, out_z
`ifdef SUM_DIFF_PE_SAT_EN
    , input sat_flag
`endif
  );

  modport slave (
    input  in_valid, in_x, in_load, in_sel, out_ready,
    output in_ready, out_valid, out_z
`ifdef SUM_DIFF_PE_SAT_EN
    , output sat_flag
`endif
  );

endinterface

// File: rtl/sum_diff_pe.sv
// One processing element: holds an operand on a load sample, otherwise
// combines its held value with the incoming operand (hold + x or hold - x)
// and registers the IN_WIDTH+1 bit result.
//
// Ports:
//   clk, rst   clock and synchronous active-high reset
//   en         global pipeline enable (low = hold everything)
//   in_valid   operand valid for this stage
//   load       store x into the hold register instead of producing a result
//   op         PE_SUM or PE_DIFF
//   x          signed operand, IN_WIDTH bits
//   z          registered signed result, IN_WIDTH+1 bits
//   sat        (SUM_DIFF_PE_SAT_EN only) this cycle's result was clipped
module sum_diff_pe
  import sum_diff_pe_pkg::*;
#(
  parameter int IN_WIDTH = 8
`ifdef SUM_DIFF_PE_SAT_EN
  ,
  parameter int DATA_WIDTH = 8
`endif
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic                       in_valid,
  input  logic                       load,
  input  pe_op_e                     op,
  input  logic signed [IN_WIDTH-1:0] x,
  output logic signed [IN_WIDTH:0]   z
`ifdef SUM_DIFF_PE_SAT_EN
  ,
  output logic                       sat
`endif
);

  logic signed [IN_WIDTH-1:0] hold;
  logic signed [IN_WIDTH:0]   full;
  logic signed [IN_WIDTH:0]   result;

  // Both operands are sign-extended by one bit so the sum/difference can
  // never overflow; the held value is always the minuend.
  always_comb begin
    full = {hold[IN_WIDTH-1], hold} + {x[IN_WIDTH-1], x};
    if (op == PE_DIFF) begin
      full = {hold[IN_WIDTH-1], hold} - {x[IN_WIDTH-1], x};
    end
  end

`ifdef SUM_DIFF_PE_SAT_EN
  localparam logic signed [IN_WIDTH:0] SAT_HI = (IN_WIDTH + 1)'(sat_bound(DATA_WIDTH, 1'b1));
  localparam logic signed [IN_WIDTH:0] SAT_LO = (IN_WIDTH + 1)'(sat_bound(DATA_WIDTH, 1'b0));

  // Clip to the signed DATA_WIDTH range; the clipped value is still carried
  // sign-extended at the full stage width.
  always_comb begin
    result = full;
    sat    = 1'b0;
    if (full > SAT_HI) begin
      result = SAT_HI;
      sat    = 1'b1;
    end else if (full < SAT_LO) begin
      result = SAT_LO;
      sat    = 1'b1;
    end
  end
`else
  assign result = full;
`endif

  // A load only updates the hold register; a non-load only updates the
  // result, so the held operand survives any number of uses.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold <= '0;
      z    <= '0;
    end else if (en && in_valid) begin
      if (load) begin
        hold <= x;
      end else begin
        z <= result;
      end
    end
  end

endmodule

// File: rtl/sum_diff_pe_array.sv
// Multi-lane, multi-stage sum/difference PE array for butterfly
// pre-processing. Each of CHANNELS lanes is a chain of STAGES PEs sharing one
// set of controls; stage k's load/sel bits ride along with the sample so
// they reach stage k together with its data. A single enable
// (en = !out_valid | out_ready) stalls the whole array.
//
// Ports:
//   clk  clock
//   rst  synchronous active-high reset (clears holds, valids, outputs)
//   bus  sum_diff_pe_array_if.slave handshake/data bundle
// Optional: define SUM_DIFF_PE_SAT_EN to saturate every stage result to the
// signed DATA_WIDTH range and drive bus.sat_flag.
module sum_diff_pe_array
  import sum_diff_pe_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 4,
  parameter int STAGES     = 2
) (
  input logic                clk,
  input logic                rst,
  sum_diff_pe_array_if.slave bus
);

  logic en;
  logic out_valid_q;

  assign en           = !out_valid_q | bus.out_ready;
  assign bus.in_ready = en;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int IW = DATA_WIDTH + k;
    localparam int CW = STAGES - k;

    // Inputs to stage k: data, valid, and the control bits still unused.
    logic                     stg_valid;
    logic [CHANNELS*IW-1:0]   stg_x;
    logic [CW-1:0]            stg_load;
    logic [CW-1:0]            stg_sel;
    // Registered outputs of stage k feeding stage k+1 (or the array output).
    logic                     q_valid;
    logic [CHANNELS*(IW+1)-1:0] q_z;
`ifdef SUM_DIFF_PE_SAT_EN
    logic                     stg_sat;
    logic [CHANNELS-1:0]      lane_sat;
    logic                     q_sat;
`endif

    if (k == 0) begin : g_src
      assign stg_valid = bus.in_valid & en;
      assign stg_x     = bus.in_x;
      assign stg_load  = bus.in_load;
      assign stg_sel   = bus.in_sel;
`ifdef SUM_DIFF_PE_SAT_EN
      assign stg_sat   = 1'b0;
`endif
    end else begin : g_src
      assign stg_valid = g_stage[k-1].q_valid;
      assign stg_x     = g_stage[k-1].q_z;
      assign stg_load  = g_stage[k-1].g_ctl.q_load;
      assign stg_sel   = g_stage[k-1].g_ctl.q_sel;
`ifdef SUM_DIFF_PE_SAT_EN
      assign stg_sat   = g_stage[k-1].q_sat;
`endif
    end

    // Bit 0 of the control vectors is consumed here; the rest is delayed
    // one cycle so it lines up with the sample at the next stage.
    if (k < STAGES - 1) begin : g_ctl
      logic [CW-2:0] q_load;
      logic [CW-2:0] q_sel;

      always_ff @(posedge clk) begin
        if (rst) begin
          q_load <= '0;
          q_sel  <= '0;
        end else if (en) begin
          q_load <= stg_load[CW-1:1];
          q_sel  <= stg_sel[CW-1:1];
        end
      end
    end

    // A load consumes the sample, so nothing is passed downstream.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_valid <= 1'b0;
      end else if (en) begin
        q_valid <= stg_valid & ~stg_load[0];
      end
    end

`ifdef SUM_DIFF_PE_SAT_EN
    // The flag accumulates clipping along the sample's path through the chain.
    always_ff @(posedge clk) begin
      if (rst) begin
        q_sat <= 1'b0;
      end else if (en && stg_valid && !stg_load[0]) begin
        q_sat <= stg_sat | (|lane_sat);
      end
    end
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
      sum_diff_pe #(
        .IN_WIDTH  (IW)
`ifdef SUM_DIFF_PE_SAT_EN
        ,
        .DATA_WIDTH(DATA_WIDTH)
`endif
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .in_valid(stg_valid),
        .load    (stg_load[0]),
        .op      (pe_op_e'(stg_sel[0])),
        .x       (stg_x[c*IW +: IW]),
        .z       (q_z[c*(IW+1) +: IW+1])
`ifdef SUM_DIFF_PE_SAT_EN
        ,
        .sat     (lane_sat[c])
`endif
      );
    end
  end

  assign out_valid_q   = g_stage[STAGES-1].q_valid;
  assign bus.out_valid = out_valid_q;
  assign bus.out_z     = g_stage[STAGES-1].q_z;
`ifdef SUM_DIFF_PE_SAT_EN
  assign bus.sat_flag  = g_stage[STAGES-1].q_sat;
`endif

endmodule

// File: tb/tb_sum_diff_pe_array.sv
// Self-checking bench for sum_diff_pe_array (4 lanes, 2 stages, 8-bit).
// Directed scenarios plus a randomized phase, all checked against a
// per-sample reference model of the stage chain and a result scoreboard.
module tb_sum_diff_pe_array;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int ST = 2;
  localparam int OW = DW + ST;
  localparam longint SAT_HI = (64'sd1 <<< (DW - 1)) - 1;
  localparam longint SAT_LO = -(64'sd1 <<< (DW - 1));

  logic clk;
  logic rst;

  int checks;
  int errors;
  int cyc;
  int outCount;
  bit monitorOn;
  bit checkLatency;
  bit randomPhase;

  longint holdM [ST][CH];
  logic [CH*OW-1:0] expQ[$];
  logic satQ[$];
  int accQ[$];
  longint lastZ [CH];
  logic lastSat;
  bit prevStall;
  longint prevZ [CH];

  logic [ST-1:0] rLoad;
  logic [ST-1:0] rSel;
  logic [CH*DW-1:0] rX;

  sum_diff_pe_array_if #(.DATA_WIDTH(DW), .CHANNELS(CH), .STAGES(ST)) bus ();

  sum_diff_pe_array #(.DATA_WIDTH(DW), .CHANNELS(CH), .STAGES(ST)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input longint observed, input longint expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", tag, observed, expected, cyc);
    end
  endtask

  function automatic longint laneZ(input int c);
    return longint'($signed(bus.out_z[c*OW +: OW]));
  endfunction

  function automatic longint laneOf(input logic [CH*OW-1:0] v, input int c);
    return longint'($signed(v[c*OW +: OW]));
  endfunction

  function automatic logic [CH*DW-1:0] packLanes(input int a, input int b, input int c, input int d);
    logic [CH*DW-1:0] v;
    v[0*DW +: DW] = DW'(a);
    v[1*DW +: DW] = DW'(b);
    v[2*DW +: DW] = DW'(c);
    v[3*DW +: DW] = DW'(d);
    return v;
  endfunction

  function automatic logic [CH*DW-1:0] packAll(input int a);
    return packLanes(a, a, a, a);
  endfunction

  // Reference: walk one accepted sample through the stage chain with plain
  // integer arithmetic; a load at any stage ends its journey.
  task automatic modelAccept(input logic [CH*DW-1:0] x, input logic [ST-1:0] ld, input logic [ST-1:0] sl);
    longint v [CH];
    logic sat;
    logic [CH*OW-1:0] vec;
    sat = 1'b0;
    vec = '0;
    for (int c = 0; c < CH; c++) v[c] = longint'($signed(x[c*DW +: DW]));
    for (int k = 0; k < ST; k++) begin
      if (ld[k]) begin
        for (int c = 0; c < CH; c++) holdM[k][c] = v[c];
        return;
      end
      for (int c = 0; c < CH; c++) begin
        longint r;
        r = sl[k] ? holdM[k][c] - v[c] : holdM[k][c] + v[c];
`ifdef SUM_DIFF_PE_SAT_EN
        if (r > SAT_HI) begin
          r = SAT_HI;
          sat = 1'b1;
        end else if (r < SAT_LO) begin
          r = SAT_LO;
          sat = 1'b1;
        end
`endif
        v[c] = r;
      end
    end
    for (int c = 0; c < CH; c++) vec[c*OW +: OW] = v[c][OW-1:0];
    expQ.push_back(vec);
    satQ.push_back(sat);
    accQ.push_back(cyc);
  endtask

  task automatic modelReset();
    for (int k = 0; k < ST; k++)
      for (int c = 0; c < CH; c++) holdM[k][c] = 0;
    expQ.delete();
    satQ.delete();
    accQ.delete();
  endtask

  // Mid-cycle monitor: handshake rule, stall stability, scoreboard.
  always @(negedge clk) begin
    if (monitorOn) begin
      if (rst) begin
        modelReset();
        prevStall = 1'b0;
      end else begin
        checkOutput("in_ready_rule", longint'(bus.in_ready), longint'(!bus.out_valid || bus.out_ready));
        if (prevStall) begin
          checkOutput("stall_out_valid", longint'(bus.out_valid), 1);
          for (int c = 0; c < CH; c++) checkOutput("stall_out_z", laneZ(c), prevZ[c]);
        end
        if (bus.out_valid && bus.out_ready) begin
          outCount++;
          if (expQ.size() == 0) begin
            checkOutput("unexpected_out", 1, 0);
          end else begin
            logic [CH*OW-1:0] e;
            logic es;
            int acc;
            e = expQ.pop_front();
            es = satQ.pop_front();
            acc = accQ.pop_front();
            for (int c = 0; c < CH; c++) checkOutput("out_z", laneZ(c), laneOf(e, c));
`ifdef SUM_DIFF_PE_SAT_EN
            checkOutput("sat_flag", longint'(bus.sat_flag), longint'(es));
            lastSat = bus.sat_flag;
`else
            lastSat = es;
`endif
            if (checkLatency) checkOutput("latency", cyc - acc, ST);
          end
          for (int c = 0; c < CH; c++) lastZ[c] = laneZ(c);
        end
        if (bus.in_valid && bus.in_ready) modelAccept(bus.in_x, bus.in_load, bus.in_sel);
        prevStall = bus.out_valid && !bus.out_ready;
        for (int c = 0; c < CH; c++) prevZ[c] = laneZ(c);
      end
    end
  end

  task automatic resetDut();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // Present one sample (or a bubble) and hold it until accepted.
  task automatic applyStimulus(input logic v, input logic [ST-1:0] ld, input logic [ST-1:0] sl,
                               input logic [CH*DW-1:0] x);
    int guard;
    logic took;
    guard = 0;
    bus.in_valid = v;
    bus.in_load  = ld;
    bus.in_sel   = sl;
    bus.in_x     = x;
    do begin
      @(negedge clk);
      took = bus.in_ready | ~v | rst;
      @(posedge clk);
      #1;
      guard++;
    end while (!took && guard < 50);
    if (!took) checkOutput("accept_timeout", 0, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int guard;
    guard = 0;
    bus.out_ready = 1'b1;
    while ((expQ.size() != 0 || bus.out_valid) && guard < 40) begin
      @(posedge clk);
      #1;
      guard++;
    end
    checkOutput("drain_pending", expQ.size(), 0);
    checkOutput("drain_out_valid", longint'(bus.out_valid), 0);
  endtask

  initial begin
    int base;
    int guard;
    checks = 0;
    errors = 0;
    cyc = 0;
    outCount = 0;
    monitorOn = 1'b0;
    checkLatency = 1'b0;
    randomPhase = 1'b0;
    prevStall = 1'b0;
    lastSat = 1'b0;
    for (int c = 0; c < CH; c++) lastZ[c] = 0;
    modelReset();
    bus.in_valid = 1'b0;
    bus.in_x = '0;
    bus.in_load = '0;
    bus.in_sel = '0;
    bus.out_ready = 1'b1;
    rst = 1'b1;

    resetDut();
    monitorOn = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", longint'(bus.out_valid), 0);
    for (int c = 0; c < CH; c++) checkOutput("rst_out_z", laneZ(c), 0);
    checkOutput("rst_in_ready", longint'(bus.in_ready), 1);
`ifdef SUM_DIFF_PE_SAT_EN
    checkOutput("rst_sat_flag", longint'(bus.sat_flag), 0);
`endif
    @(posedge clk);
    #1;

    $display("[TB] load 3 then sum 5");
    checkLatency = 1'b1;
    applyStimulus(1'b1, 2'b01, 2'b00, packAll(3));
    applyStimulus(1'b1, 2'b00, 2'b00, packAll(5));
    waitDrain();
    checkOutput("sum_3_5", lastZ[0], 8);

    $display("[TB] load 3 then difference 5");
    resetDut();
    applyStimulus(1'b1, 2'b01, 2'b00, packAll(3));
    applyStimulus(1'b1, 2'b00, 2'b01, packAll(5));
    waitDrain();
    checkOutput("diff_3_5", lastZ[0], -2);

    $display("[TB] non-load straight after reset");
    resetDut();
    applyStimulus(1'b1, 2'b00, 2'b00, packAll(4));
    waitDrain();
    checkOutput("initial_hold", lastZ[0], 4);

    $display("[TB] two-stage butterfly");
    resetDut();
    base = outCount;
    applyStimulus(1'b1, 2'b11, 2'b00, packAll(1));
    applyStimulus(1'b1, 2'b10, 2'b00, packAll(2));
    applyStimulus(1'b1, 2'b11, 2'b00, packAll(7));
    applyStimulus(1'b1, 2'b00, 2'b01, packAll(3));
    waitDrain();
    checkOutput("butterfly_pulses", outCount - base, 1);
    checkOutput("butterfly_z", lastZ[3], 7);

    $display("[TB] four lanes with backpressure");
    resetDut();
    checkLatency = 1'b0;
    base = outCount;
    bus.out_ready = 1'b0;
    applyStimulus(1'b1, 2'b01, 2'b00, packLanes(-128, 127, 0, 1));
    applyStimulus(1'b1, 2'b00, 2'b00, packLanes(-128, 127, 0, 1));
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 10);
    checkOutput("bp_out_valid", longint'(bus.out_valid), 1);
    repeat (3) begin
      checkOutput("bp_in_ready", longint'(bus.in_ready), 0);
`ifdef SUM_DIFF_PE_SAT_EN
      checkOutput("bp_lane0", laneZ(0), -128);
      checkOutput("bp_lane1", laneZ(1), 127);
`else
      checkOutput("bp_lane0", laneZ(0), -256);
      checkOutput("bp_lane1", laneZ(1), 254);
`endif
      checkOutput("bp_lane2", laneZ(2), 0);
      checkOutput("bp_lane3", laneZ(3), 2);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    waitDrain();
    checkOutput("bp_count", outCount - base, 1);

    $display("[TB] reset mid-operation");
    resetDut();
    checkLatency = 1'b1;
    applyStimulus(1'b1, 2'b00, 2'b00, packAll(20));
    applyStimulus(1'b1, 2'b01, 2'b00, packAll(5));
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", longint'(bus.out_valid), 0);
    for (int c = 0; c < CH; c++) checkOutput("midrst_out_z", laneZ(c), 0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 2'b00, 2'b00, packAll(9));
    waitDrain();
    checkOutput("midrst_9", lastZ[0], 9);

`ifdef SUM_DIFF_PE_SAT_EN
    $display("[TB] saturation");
    resetDut();
    applyStimulus(1'b1, 2'b01, 2'b00, packLanes(100, -100, 100, -100));
    applyStimulus(1'b1, 2'b00, 2'b00, packLanes(100, -100, 100, -100));
    waitDrain();
    checkOutput("sat_pos", lastZ[0], 127);
    checkOutput("sat_neg", lastZ[1], -128);
    checkOutput("sat_flag_set", longint'(lastSat), 1);
`endif

    $display("[TB] randomized traffic");
    resetDut();
    checkLatency = 1'b0;
    randomPhase = 1'b1;
    fork
      begin
        for (int i = 0; i < 400; i++) begin
          for (int k = 0; k < ST; k++) begin
            rLoad[k] = ($urandom_range(0, 9) < 3);
            rSel[k]  = $urandom_range(0, 1) == 1;
          end
          for (int c = 0; c < CH; c++) rX[c*DW +: DW] = DW'($urandom);
          rst = ($urandom_range(0, 199) == 0);
          applyStimulus($urandom_range(0, 3) != 0, rLoad, rSel, rX);
        end
        rst = 1'b0;
        randomPhase = 1'b0;
      end
      begin
        while (randomPhase) begin
          bus.out_ready = $urandom_range(0, 3) != 0;
          @(posedge clk);
          #1;
        end
      end
    join
    waitDrain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
